// File: rtl/serial_word_receiver_if.sv
// Serial-in / parallel-out bundle for serial_word_receiver.
// The receiver takes the slave side; the producer/consumer takes the master side.
interface serial_word_receiver_if #(
    parameter int WIDTH = 4
);
    logic             frame_start;
    logic             lsb_first;
    logic             serial_valid;
    logic             serial_in;
    logic             out_ready;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    modport slave (
        input  frame_start, lsb_first, serial_valid, serial_in, out_ready,
        output parallel_out, out_valid, busy, overrun
    );

    modport master (
        output frame_start, lsb_first, serial_valid, serial_in, out_ready,
        input  parallel_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Collects WIDTH strobed serial bits after frame_start, in either bit order,
// and presents the word on a registered valid/ready output with a sticky overrun flag.
module serial_word_receiver #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_word_receiver_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d, shifted;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               order_q, order_d;
    logic               word_done;
    logic [WIDTH-1:0]   par_q;
    logic               vld_q, ovr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            order_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        order_d   = order_q;
        word_done = 1'b0;
        shifted   = order_q ? {bus.serial_in, sreg_q[WIDTH-1:1]}
                            : {sreg_q[WIDTH-2:0], bus.serial_in};
        // frame_start wins over everything, including a completing word
        if (bus.frame_start) begin
            state_d = SHIFT;
            order_d = bus.lsb_first;
            cnt_d   = '0;
            sreg_d  = '0;
            if (bus.serial_valid) begin
                sreg_d = bus.lsb_first ? {bus.serial_in, {(WIDTH-1){1'b0}}}
                                       : {{(WIDTH-1){1'b0}}, bus.serial_in};
                cnt_d  = CNT_W'(1);
            end
        end else if (state_q == SHIFT && bus.serial_valid) begin
            sreg_d = shifted;
            if (cnt_q == CNT_W'(WIDTH-1)) begin
                word_done = 1'b1;
                state_d   = IDLE;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // A completed word loads only if the output slot is empty or draining this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= '0;
            vld_q <= 1'b0;
            ovr_q <= 1'b0;
        end else if (word_done && (!vld_q || bus.out_ready)) begin
            par_q <= sreg_d;
            vld_q <= 1'b1;
        end else if (word_done) begin
            ovr_q <= 1'b1;
        end else if (vld_q && bus.out_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign bus.parallel_out = par_q;
    assign bus.out_valid    = vld_q;
    assign bus.overrun      = ovr_q;
    assign bus.busy         = (state_q == SHIFT);
endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed vector table for serial_word_receiver plus a hand-written async-reset sequence.
module tb_serial_word_receiver;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_word_receiver_if #(.WIDTH(4)) bus();
    serial_word_receiver #(.WIDTH(4), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic       r, fs, lsb, sv, si, rdy;
        logic [3:0] par;
        logic       vld, bsy, ovr;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic r, logic fs, logic lsb, logic sv, logic si, logic rdy,
                                logic [3:0] par, logic vld, logic bsy, logic ovr);
        vec_t v;
        v.r = r; v.fs = fs; v.lsb = lsb; v.sv = sv; v.si = si; v.rdy = rdy;
        v.par = par; v.vld = vld; v.bsy = bsy; v.ovr = ovr;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst              = v.r;
        bus.frame_start  = v.fs;
        bus.lsb_first    = v.lsb;
        bus.serial_valid = v.sv;
        bus.serial_in    = v.si;
        bus.out_ready    = v.rdy;
    endtask

    task automatic check(input string nm, input logic [3:0] par, input logic vld,
                         input logic bsy, input logic ovr);
        total++;
        if ({bus.parallel_out, bus.out_valid, bus.busy, bus.overrun} !== {par, vld, bsy, ovr}) begin
            bad++;
            $display("FAIL %s: got par=%b vld=%b busy=%b ovr=%b, want par=%b vld=%b busy=%b ovr=%b",
                     nm, bus.parallel_out, bus.out_valid, bus.busy, bus.overrun, par, vld, bsy, ovr);
        end
    endtask

    task automatic step(input string nm, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check(nm, v.par, v.vld, v.bsy, v.ovr);
    endtask

    initial begin
        // MSB-first 1011, ready high
        vq.push_back(mk(0,1,0,0,0,1, 4'b0000,0,1,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b0000,0,1,0));
        vq.push_back(mk(0,0,0,1,0,1, 4'b0000,0,1,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b0000,0,1,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b1011,1,0,0));
        vq.push_back(mk(0,0,0,0,0,1, 4'b1011,0,0,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b1011,0,0,0));
        // LSB-first 1011 with gaps
        vq.push_back(mk(0,1,1,0,0,1, 4'b1011,0,1,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b1011,0,1,0));
        vq.push_back(mk(0,0,0,0,0,1, 4'b1011,0,1,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b1011,0,1,0));
        vq.push_back(mk(0,0,0,0,1,1, 4'b1011,0,1,0));
        vq.push_back(mk(0,0,0,1,0,1, 4'b1011,0,1,0));
        vq.push_back(mk(0,0,0,0,1,1, 4'b1011,0,1,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b1011,1,0,0));
        vq.push_back(mk(0,0,0,0,0,1, 4'b1011,0,0,0));
        // back-pressure: 0110 held, 1001 dropped
        vq.push_back(mk(0,1,0,0,0,0, 4'b1011,0,1,0));
        vq.push_back(mk(0,0,0,1,0,0, 4'b1011,0,1,0));
        vq.push_back(mk(0,0,0,1,1,0, 4'b1011,0,1,0));
        vq.push_back(mk(0,0,0,1,1,0, 4'b1011,0,1,0));
        vq.push_back(mk(0,0,0,1,0,0, 4'b0110,1,0,0));
        vq.push_back(mk(0,1,0,0,0,0, 4'b0110,1,1,0));
        vq.push_back(mk(0,0,0,1,1,0, 4'b0110,1,1,0));
        vq.push_back(mk(0,0,0,1,0,0, 4'b0110,1,1,0));
        vq.push_back(mk(0,0,0,1,0,0, 4'b0110,1,1,0));
        vq.push_back(mk(0,0,0,1,1,0, 4'b0110,1,0,1));
        vq.push_back(mk(0,0,0,0,0,1, 4'b0110,0,0,1));
        vq.push_back(mk(1,0,0,0,0,0, 4'b0000,0,0,0));
        // 0011 pending, 1100 completes on a transfer edge
        vq.push_back(mk(0,1,0,0,0,0, 4'b0000,0,1,0));
        vq.push_back(mk(0,0,0,1,0,0, 4'b0000,0,1,0));
        vq.push_back(mk(0,0,0,1,0,0, 4'b0000,0,1,0));
        vq.push_back(mk(0,0,0,1,1,0, 4'b0000,0,1,0));
        vq.push_back(mk(0,0,0,1,1,0, 4'b0011,1,0,0));
        vq.push_back(mk(0,1,0,0,0,0, 4'b0011,1,1,0));
        vq.push_back(mk(0,0,0,1,1,0, 4'b0011,1,1,0));
        vq.push_back(mk(0,0,0,1,1,0, 4'b0011,1,1,0));
        vq.push_back(mk(0,0,0,1,0,0, 4'b0011,1,1,0));
        vq.push_back(mk(0,0,0,1,0,1, 4'b1100,1,0,0));
        vq.push_back(mk(0,0,0,0,0,1, 4'b1100,0,0,0));
        // restart mid-frame, new first bit captured with frame_start
        vq.push_back(mk(0,1,0,0,0,1, 4'b1100,0,1,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b1100,0,1,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b1100,0,1,0));
        vq.push_back(mk(0,1,0,1,0,1, 4'b1100,0,1,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b1100,0,1,0));
        vq.push_back(mk(0,0,0,1,0,1, 4'b1100,0,1,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b0101,1,0,0));
        vq.push_back(mk(0,0,0,0,0,1, 4'b0101,0,0,0));
        // frame_start in the completion cycle aborts the word
        vq.push_back(mk(0,1,0,0,0,1, 4'b0101,0,1,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b0101,0,1,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b0101,0,1,0));
        vq.push_back(mk(0,0,0,1,1,1, 4'b0101,0,1,0));
        vq.push_back(mk(0,1,0,1,1,1, 4'b0101,0,1,0));
        vq.push_back(mk(0,0,0,1,0,1, 4'b0101,0,1,0));
        vq.push_back(mk(0,0,0,1,0,1, 4'b0101,0,1,0));
        vq.push_back(mk(0,0,0,1,0,0, 4'b1000,1,0,0));
        // partial frame with a word pending, ahead of the async reset
        vq.push_back(mk(0,1,0,0,0,0, 4'b1000,1,1,0));
        vq.push_back(mk(0,0,0,1,1,0, 4'b1000,1,1,0));
        vq.push_back(mk(0,0,0,1,1,0, 4'b1000,1,1,0));

        drive(mk(1,0,0,0,0,0, 4'b0000,0,0,0));
        #2;
        check("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++)
            step($sformatf("vec%0d", i), vq[i]);

        // async reset between edges must clear everything before the next edge
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step("post_fs",  mk(0,1,0,0,0,1, 4'b0000,0,1,0));
        step("post_b1",  mk(0,0,0,1,1,1, 4'b0000,0,1,0));
        step("post_b2",  mk(0,0,0,1,1,1, 4'b0000,0,1,0));
        step("post_b3",  mk(0,0,0,1,1,1, 4'b0000,0,1,0));
        step("post_b4",  mk(0,0,0,1,0,1, 4'b1110,1,0,0));
        step("post_ack", mk(0,0,0,0,0,1, 4'b1110,0,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Serial-to-parallel receiver: the far end of the serial link driven by the team's universal shift register in shift-left or shift-right mode.
- Collects WIDTH bits from a strobed serial line after a frame_start marker and assembles them in the selected bit order.
- Presents the word on a registered parallel output with a valid/ready handshake.
- Flags words lost to back-pressure.

Parameters:
WIDTH, 4, bits per word; must be at least 2.
CNT_W, 3, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
frame_start  input  1  one-cycle marker; starts (or restarts) a word.
lsb_first  input  1  bit order for the frame: 1 = LSB arrives first (shift-right source), 0 = MSB first (shift-left source). Sampled only with frame_start.
serial_valid  input  1  a bit is present on serial_in this cycle.
serial_in  input  1  serial data bit.
out_ready  input  1  consumer accepts parallel_out this cycle.
parallel_out  output  WIDTH  assembled word, registered.
out_valid  output  1  parallel_out holds an unconsumed word.
busy  output  1  high while in state SHIFT.
overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (async, immediate): state=IDLE, shift reg=0, bit count=0, order latch=0, parallel_out=0, out_valid=0, busy=0, overrun=0. Reset mid-frame discards the partial word and any pending output.
- States: IDLE and SHIFT.
  - IDLE: serial_valid is ignored unless frame_start is high.
  - frame_start=1 in IDLE:
    - latch lsb_first, clear count, go to SHIFT.
    - If serial_valid=1 in the same cycle, that bit is captured as bit 1 of the word.
  - SHIFT: each cycle with serial_valid=1 shifts one bit in and increments the count. Cycles with serial_valid=0 hold everything; gaps are unlimited.
  - frame_start=1 in SHIFT: abort the partial word, relatch lsb_first, reset count. A same-cycle serial_valid bit becomes bit 1 of the new word. No flag is raised.
- Shift rules:
  - MSB-first: sreg <= {sreg[WIDTH-2:0], serial_in}.
  - LSB-first: sreg <= {serial_in, sreg[WIDTH-1:1]}.
- Word completion, on the edge capturing bit WIDTH:
  - The assembled word, including that bit, is written directly to parallel_out, and out_valid=1 after the same edge. Latency is zero extra cycles.
  - State returns to IDLE; the next word needs a new frame_start.
  - A frame_start in the completion cycle takes priority: it aborts the completing word, and no load or overrun occurs.
- Output handshake:
  - A transfer occurs on any edge where out_valid=1 and out_ready=1.
  - After a transfer, out_valid=0 unless a new word loads on the same edge.
  - parallel_out keeps its last value after a transfer; it does not clear.
  - parallel_out is stable while out_valid=1 and out_ready=0.
- Simultaneous completion and pending output:
  - out_valid=1 and out_ready=1: the old word transfers, the new word loads, out_valid stays 1, overrun unchanged.
  - out_valid=1 and out_ready=0: the new word is dropped, the old word is retained, overrun<=1.
- overrun clears only on rst.
- busy is combinational from state (SHIFT).
- No combinational path from inputs to parallel_out or out_valid.

Test Plan:
- MSB-first, WIDTH=4: rst 1→0; frame_start with lsb_first=0, then serial bits 1,0,1,1 on consecutive cycles with out_ready=1 → parallel_out=4'b1011 and out_valid=1 for exactly one cycle after the 4th bit edge; busy high for the bit cycles only.
- LSB-first with gaps: frame_start with lsb_first=1; bits 1,1,0,1 with serial_valid=0 idle cycles between them → parallel_out=4'b1011, and the count is unaffected by the gaps.
- Back-pressure/overrun: out_ready=0; receive 4'b0110, then a second frame 4'b1001 → parallel_out stays 4'b0110, out_valid=1, overrun=1. Then out_ready=1 → out_valid=0 next cycle, overrun remains 1.
- Simultaneous transfer and load: hold word 4'b0011 pending; complete word 4'b1100 on the same edge where out_ready=1 → parallel_out=4'b1100, out_valid stays 1, overrun=0.
- Restart mid-frame: send 2 bits (1,1), then frame_start with bits 0,1,0,1 (MSB-first) → parallel_out=4'b0101, with no word emitted for the aborted partial.
- Async reset mid-frame: assert rst between clock edges after 2 bits → all outputs 0 immediately. After release, a full frame of 4'b1110 → parallel_out=4'b1110 with no stale bits.
